// File: rtl/clock_pkg.sv
// Shared types for the button event decoder: FSM states and o_sw_state event codes.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HELD = 3'd1,
    ST_LONG = 3'd2,
    ST_CLR  = 3'd3,
    ST_REL  = 3'd4
  } state_e;

  localparam logic [1:0] CODE_IDLE  = 2'b11;
  localparam logic [1:0] CODE_SHORT = 2'b10;
  localparam logic [1:0] CODE_LONG  = 2'b01;
  localparam logic [1:0] CODE_CLR   = 2'b00;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus stability counter for an active-low pushbutton.
// Exposes the debounced level (1 = pressed) and one-cycle press/release pulses.
module sync_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] DEB_V = CW'(DEB_CYC);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          sample_pressed;

  // The level flips on the cycle after the counter has seen DEB_CYC differing samples.
  always_comb begin
    sync_d         = {sync_q[0], i_sw};
    sample_pressed = ~sync_q[1];
    level_d        = level_q;
    cnt_d          = '0;
    press_d        = 1'b0;
    release_d      = 1'b0;
    if (sample_pressed != level_q) begin
      if (cnt_q == DEB_V) begin
        level_d   = sample_pressed;
        press_d   = sample_pressed;
        release_d = ~sample_pressed;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into short, long and clear-request events.
// Codes: 11 idle, 10 short pulse, 01 long pulse, 00 clear level until release.
module button_event_decoder
  import clock_pkg::*;
#(
  parameter int DEB_CYC  = 1_000_000,
  parameter int LONG_CYC = 50_000_000,
  parameter int CLR_CYC  = 150_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sw,
  output logic [1:0] o_sw_state,
  output logic       o_pressed
);

  localparam int HW = $clog2(CLR_CYC + 1);
  localparam logic [HW-1:0] LONG_V = HW'(LONG_CYC);
  localparam logic [HW-1:0] CLR_V  = HW'(CLR_CYC);

  logic          level, press_evt, release_evt;
  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;

  sync_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_sync_debounce (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_sw     (i_sw),
    .o_level  (level),
    .o_press  (press_evt),
    .o_release(release_evt)
  );

  // Hold counter saturates at CLR_CYC; a release always takes priority over a threshold.
  always_comb begin
    hold_inc   = (hold_q == CLR_V) ? hold_q : hold_q + HW'(1);
    state_d    = state_q;
    hold_d     = hold_q;
    o_sw_state = CODE_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (press_evt) begin
          state_d = ST_HELD;
          hold_d  = HW'(1);
        end
      end
      ST_HELD: begin
        if (release_evt) begin
          state_d = ST_REL;
          hold_d  = '0;
        end else begin
          hold_d = hold_inc;
          if (hold_inc == LONG_V) state_d = ST_LONG;
        end
      end
      ST_LONG: begin
        // Only the entry cycle of LONG carries the long-press pulse.
        if (hold_q == LONG_V) o_sw_state = CODE_LONG;
        if (release_evt) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_inc;
          if (hold_inc == CLR_V) state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        o_sw_state = CODE_CLR;
        if (release_evt) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_inc;
        end
      end
      ST_REL: begin
        o_sw_state = CODE_SHORT;
        state_d    = ST_IDLE;
        hold_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign o_pressed = level;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with DEB_CYC=4, LONG_CYC=20, CLR_CYC=40.
// Expected per-cycle outputs come from hand-derived event offsets in a vector table.
module tb_button_event_decoder;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int CLR  = 40;

  logic       clk;
  logic       rst;
  logic       sw;
  logic [1:0] sw_state;
  logic       pressed;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  // Offsets are relative to edge N, the first posedge that samples i_sw low.
  // rise/fall bound o_pressed high as [rise, fall); -1 means the event must not occur.
  typedef struct {
    string name;
    int    low1;
    int    high1;
    int    low2;
    int    rise;
    int    fall;
    int    short_at;
    int    long_at;
    int    clr_from;
    int    clr_to;
  } vec_t;

  typedef struct {
    int         at;
    logic [1:0] code;
    logic       pressed;
    string      name;
  } sb_entry_t;

  sb_entry_t sb[$];
  vec_t      vecs[10];
  vec_t      post_reset;

  button_event_decoder #(
    .DEB_CYC (DEB),
    .LONG_CYC(LONG),
    .CLR_CYC (CLR)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sw      (sw),
    .o_sw_state(sw_state),
    .o_pressed (pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic vec_t mkVec(input string n, input int l1, input int h1, input int l2,
                                 input int r, input int f, input int s, input int l,
                                 input int cf, input int ct);
    vec_t v;
    v.name = n; v.low1 = l1; v.high1 = h1; v.low2 = l2;
    v.rise = r; v.fall = f; v.short_at = s; v.long_at = l;
    v.clr_from = cf; v.clr_to = ct;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int at, input logic [1:0] exp_code,
                             input logic exp_pressed);
    checks++;
    if (sw_state !== exp_code || pressed !== exp_pressed) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d o_sw_state=%b (expected %b) o_pressed=%b (expected %b)",
               name, at, sw_state, exp_code, pressed, exp_pressed);
    end
  endtask

  // Called just after a negedge; drives one input value per cycle and queues the
  // outputs expected after the posedge that samples it.
  task automatic applyStimulus(input vec_t v);
    int        total;
    sb_entry_t e;
    logic      low;
    total = v.low1 + v.high1 + v.low2 + 15;
    for (int i = 0; i < total; i++) begin
      low = (i < v.low1) || (i >= v.low1 + v.high1 && i < v.low1 + v.high1 + v.low2);
      e.at      = cyc + 1;
      e.name    = v.name;
      e.pressed = (v.rise >= 0) && (i >= v.rise) && (i < v.fall);
      if (i == v.short_at)                                     e.code = 2'b10;
      else if (i == v.long_at)                                 e.code = 2'b01;
      else if (v.clr_from >= 0 && i >= v.clr_from && i <= v.clr_to) e.code = 2'b00;
      else                                                     e.code = 2'b11;
      sb.push_back(e);
      sw = ~low;
      @(negedge clk);
    end
  endtask

  // Scoreboard consumer: compares each queued expectation on the negedge of its cycle.
  always @(negedge clk) begin
    sb_entry_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s missed cyc=%0d now=%0d", e.name, e.at, cyc);
      end else begin
        checkOutput(e.name, e.at, e.code, e.pressed);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired at cyc=%0d (expected completion)", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = mkVec("short10",     10, 0, 0, 6, 16, 17, -1, -1, -1);
    vecs[1] = mkVec("long30",      30, 0, 0, 6, 36, -1, 26, -1, -1);
    vecs[2] = mkVec("clr60",       60, 0, 0, 6, 66, -1, 26, 46, 66);
    vecs[3] = mkVec("glitch_rel",   3, 3, 3, -1, -1, -1, -1, -1, -1);
    vecs[4] = mkVec("glitch_held",  6, 3, 6, 6, 21, 22, -1, -1, -1);
    vecs[5] = mkVec("short19",     19, 0, 0, 6, 25, 26, -1, -1, -1);
    vecs[6] = mkVec("long20",      20, 0, 0, 6, 26, -1, 26, -1, -1);
    vecs[7] = mkVec("clr40",       40, 0, 0, 6, 46, -1, 26, 46, 46);
    vecs[8] = mkVec("min5",         5, 0, 0, 6, 11, 12, -1, -1, -1);
    vecs[9] = mkVec("too_short4",   4, 0, 0, -1, -1, -1, -1, -1, -1);
    post_reset = mkVec("post_reset", 10, 0, 0, 6, 16, 17, -1, -1, -1);

    rst = 1'b1;
    sw  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", cyc, 2'b11, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_after_reset", cyc, 2'b11, 1'b0);

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Reset at hold count 15 with the button still held: the press is discarded
    // and the held button re-enters through the debounce path as a fresh press.
    sw = 1'b0;
    repeat (22) @(negedge clk);
    checkOutput("pre_reset_held", cyc, 2'b11, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("reset_async", cyc, 2'b11, 1'b0);
    @(negedge clk);
    checkOutput("reset_hold1", cyc, 2'b11, 1'b0);
    @(negedge clk);
    checkOutput("reset_hold2", cyc, 2'b11, 1'b0);
    rst = 1'b0;
    applyStimulus(post_reset);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain left=%0d (expected 0)", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named i_clk and i_rst.
REQ-002 Parameter DEB_CYC, default 1_000_000, is the number of stable cycles required to accept a level change (20 ms at 50 MHz).
REQ-003 Parameter LONG_CYC, default 50_000_000, is the hold duration in cycles that classifies a press as long (1 s).
REQ-004 Parameter CLR_CYC, default 150_000_000, is the hold duration in cycles that requests a clock clear (3 s); CLR_CYC SHALL be greater than LONG_CYC, which SHALL be greater than DEB_CYC.
REQ-005 i_clk  input  1  system clock.
REQ-006 i_rst  input  1  async active-high reset.
REQ-007 i_sw  input  1  raw asynchronous pushbutton, active-low (0 = pressed).
REQ-008 o_sw_state  output  2  event code: 11 idle, 10 short-press pulse, 01 long-press pulse, 00 clear request (level).
REQ-009 o_pressed  output  1  debounced button level, 1 = pressed.

Function
REQ-010 i_sw SHALL pass through a two-flop synchronizer before any other use.
REQ-011 The debounced level SHALL change only after DEB_CYC consecutive synchronized samples differ from it; any sample equal to the current level SHALL zero the stability counter.
REQ-012 If i_sw is sampled low at edge N and remains low, o_pressed SHALL rise at edge N+2+DEB_CYC.
REQ-013 The FSM SHALL have states IDLE, HELD, LONG, CLR and REL.
REQ-014 IDLE->HELD on the debounced press edge; the hold counter loads 1 and increments each cycle while pressed, saturating at CLR_CYC.
REQ-015 HELD->LONG when the hold counter reaches LONG_CYC; o_sw_state SHALL be 01 for exactly that one cycle.
REQ-016 LONG->CLR when the hold counter reaches CLR_CYC; o_sw_state SHALL be 00 from that cycle until the debounced release.
REQ-017 HELD->REL on debounced release with hold < LONG_CYC; o_sw_state SHALL be 10 for exactly the one cycle following the release edge.
REQ-018 A release from LONG or CLR SHALL produce no pulse; o_sw_state returns to 11 on the cycle after the release.
REQ-019 REL->IDLE unconditionally after one cycle; at most one event code is issued per press, except the 01 pulse that precedes a 00 level.
REQ-020 Glitches shorter than DEB_CYC during press or release SHALL not alter state, counters or outputs.
REQ-021 In all cycles not listed in REQ-015 to REQ-017, o_sw_state SHALL be 11.

Reset
REQ-022 While i_rst is high, all outputs and state SHALL be forced: o_sw_state = 11, o_pressed = 0, FSM = IDLE, counters = 0, synchronizer flops = 1.
REQ-023 Reset asserted mid-press SHALL discard the press; after deassertion, a still-held button SHALL be treated as a new press via the debounce path of REQ-012.

Structure
REQ-024 The FSM state enumeration and the four o_sw_state codes SHALL live in a shared package, clock_pkg.
REQ-025 The synchronizer plus stability counter SHALL be one sub-module, sync_debounce, with outputs for level and press/release edge pulses.
REQ-026 The hold counter width SHALL be $clog2(CLR_CYC+1); the stability counter width SHALL be $clog2(DEB_CYC+1).

Verification (DEB_CYC=4, LONG_CYC=20, CLR_CYC=40)
REQ-027 Hold i_sw low for 10 cycles, then release -> o_pressed rises 6 cycles after the fall; exactly one 10 pulse after the debounced release; no 01.
REQ-028 Hold low for 30 cycles -> a single 01 pulse at hold count 20; no 10 on release; o_sw_state = 11 afterwards.
REQ-029 Hold low for 60 cycles -> 01 at hold count 20; 00 from hold count 40 until the cycle after the debounced release; then 11.
REQ-030 Toggle i_sw with 3-cycle pulses while released, and with 3-cycle highs while held -> o_pressed and o_sw_state unchanged.
REQ-031 Assert i_rst at hold count 15 for 2 cycles, with the button still held -> outputs 11/0 immediately; o_pressed rises again DEB_CYC+2 cycles after deassertion; no 10 pulse from the aborted press.
